// File: rtl/count_window_arbiter.sv
// Round-robin arbiter that lends a shared 0-15 window counter to one requester per window.
// Optional WAIT_RISE timeout with sticky err is enabled by defining COUNT_ARB_TIMEOUT_EN.
module count_window_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic             start_count,
    input  logic             counting,
    input  logic [3:0]       result,
    output logic [3:0]       window_pos,
    output logic             err
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("count_window_arbiter: N_REQ must be 2..8");
    end
    if ((1 << IDX_W) < N_REQ) begin : g_bad_idxw
        $error("count_window_arbiter: IDX_W too narrow for N_REQ");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("count_window_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_RISE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic [N_REQ-1:0]   req_rot;
    int                 scan_j;

`ifdef COUNT_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    // First requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        req_rot   = '0;
        scan_j    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_j  = (int'(ptr_q) + i) % N_REQ;
            req_rot = req >> scan_j;
            if (!win_found && req_rot[0]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_j);
                win_oh    = N_REQ'(1) << scan_j;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef COUNT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef COUNT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef COUNT_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            // A counter still running from before (power-up or our own reset) blocks arbitration.
            S_IDLE: begin
                if (!counting && win_found) begin
                    state_d = S_START;
                    grant_d = win_oh;
                    idx_d   = win_idx;
                end
            end
            S_START: begin
                state_d = S_WAIT_RISE;
`ifdef COUNT_ARB_TIMEOUT_EN
                cnt_d   = TO_W'(TIMEOUT - 1);
`endif
            end
            S_WAIT_RISE: begin
                if (counting) begin
                    state_d = S_RUN;
                end
`ifdef COUNT_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (!counting) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                grant_d = '0;
                idx_d   = '0;
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        start_count = (state_q == S_START);
        done        = (state_q == S_FINISH) ? grant_q : '0;
        window_pos  = (state_q == S_RUN) ? result : 4'd0;
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;

`ifdef COUNT_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_count_window_arbiter.sv
// Scoreboard bench for count_window_arbiter with a behavioural 0-15 window counter.
module tb_count_window_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] grant;
    logic [2:0] grant_idx;
    logic [3:0] done;
    logic       busy;
    logic       start_count;
    logic       counting;
    logic [3:0] result;
    logic [3:0] window_pos;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cnt_mode = 1;  // 0: normal counter, 1: held busy, 2: dead (never counts)
    logic [3:0] exp_q[$];

    count_window_arbiter #(.N_REQ(4), .IDX_W(3), .TIMEOUT(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .req(req),
        .grant(grant),
        .grant_idx(grant_idx),
        .done(done),
        .busy(busy),
        .start_count(start_count),
        .counting(counting),
        .result(result),
        .window_pos(window_pos),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counter model: start_count seen on an edge -> counting with result 0..15 for 16 cycles.
    initial begin
        logic st;
        counting = 1'b1;
        result   = 4'd15;
        forever begin
            @(negedge clk);
            st = start_count;
            @(posedge clk);
            #1;
            case (cnt_mode)
                1: begin counting = 1'b1; result = 4'd15; end
                2: begin counting = 1'b0; result = 4'd0; end
                default: begin
                    if (st && !counting) begin
                        counting = 1'b1;
                        result   = 4'd0;
                    end else if (counting) begin
                        if (result == 4'd15) begin
                            counting = 1'b0;
                            result   = 4'd0;
                        end else begin
                            result = result + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic run_window(input bit drop, output int wait_n);
        logic [3:0] e;
        logic [2:0] eidx;
        int n, k, sc, maxpos;
        bit posbad, ohbad;
        logic p, pp;
        n = 0;
        while (grant === 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        wait_n = n;
        e = exp_q.pop_front();
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL grant_wait: no grant after %0d cycles, expected %b", n, e);
            return;
        end
        checks++;
        if (grant !== e) begin
            errors++;
            $display("FAIL grant_value: got %b expected %b", grant, e);
        end
        eidx = 3'd0;
        for (int b = 0; b < 4; b++) if (e[b]) eidx = 3'(b);
        checks++;
        if (grant_idx !== eidx) begin
            errors++;
            $display("FAIL grant_idx: got %0d expected %0d", grant_idx, eidx);
        end
        k = 0; sc = 0; maxpos = 0; posbad = 0; ohbad = 0; p = 1'b0; pp = 1'b0;
        while (done === 4'b0 && k < 80) begin
            if (start_count === 1'b1) sc++;
            if (!$onehot(grant)) ohbad = 1;
            if (window_pos !== 4'd0 && window_pos !== result) posbad = 1;
            if (int'(window_pos) > maxpos) maxpos = int'(window_pos);
            if (drop && maxpos >= 5) req = 4'b0;
            pp = p;
            p  = counting;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 80) begin
            errors++;
            $display("FAIL done_wait: no done after %0d cycles for grant %b", k, e);
            return;
        end
        checks++;
        if (done !== e) begin
            errors++;
            $display("FAIL done_value: got %b expected %b", done, e);
        end
        checks++;
        if (sc != 1) begin
            errors++;
            $display("FAIL start_pulse: start_count high %0d cycles expected 1", sc);
        end
        checks++;
        if (ohbad) begin
            errors++;
            $display("FAIL grant_onehot: grant not one-hot during window %b", e);
        end
        checks++;
        if (posbad || maxpos != 15) begin
            errors++;
            $display("FAIL window_pos: max %0d expected 15, passthrough_bad=%0d", maxpos, posbad);
        end
        checks++;
        if (!(p === 1'b0 && pp === 1'b1)) begin
            errors++;
            $display("FAIL done_latency: counting before done was %b,%b expected 1,0", pp, p);
        end
        @(negedge clk);
        checks++;
        if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b grant=%b busy=%b expected 0000 0000 0", done, grant, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_grant: grant=%b idx=%0d expected 0", grant, grant_idx);
        end
        checks++;
        if ({done, busy, start_count, err, window_pos} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b busy=%b start=%b err=%b pos=%0d expected 0",
                     done, busy, start_count, err, window_pos);
        end
        resetn = 1'b1;
    endtask

    task automatic test_powerup_busy();
        bit blocked_ok;
        int n;
        req = 4'b0001;
        blocked_ok = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (grant !== 4'b0 || busy !== 1'b0) blocked_ok = 0;
        end
        checks++;
        if (!blocked_ok) begin
            errors++;
            $display("FAIL powerup_block: grant=%b busy=%b while counting, expected none", grant, busy);
        end
        exp_q.push_back(4'b0001);
        cnt_mode = 0;
        @(negedge clk);
        checks++;
        if (counting !== 1'b0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL powerup_fall: counting=%b grant=%b expected 0 0000", counting, grant);
        end
        run_window(0, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL powerup_latency: grant after %0d cycles expected 1", n);
        end
        req = 4'b0;
    endtask

    task automatic test_round_robin();
        int n;
        req = 4'b1111;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        for (int w = 0; w < 5; w++) run_window(0, n);
        // pointer now 2: scan 2,3 then wraps to 0
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        run_window(0, n);
        run_window(0, n);
        req = 4'b0;
    endtask

    task automatic test_drop_req();
        int n;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        run_window(1, n);
        req = 4'b0;
    endtask

    task automatic test_reset_mid_window();
        logic [3:0] e;
        int n, hi;
        bit idle_ok;
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        n = 0;
        while (grant === 4'b0 && n < 60) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        checks++;
        if (grant !== e) begin
            errors++;
            $display("FAIL rst_pre_grant: got %b expected %b", grant, e);
        end
        n = 0;
        while (int'(window_pos) < 4 && n < 60) begin @(negedge clk); n++; end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({grant, grant_idx, busy, done, start_count, window_pos} !== 18'b0) begin
            errors++;
            $display("FAIL rst_async: grant=%b idx=%0d busy=%b done=%b start=%b pos=%0d expected 0",
                     grant, grant_idx, busy, done, start_count, window_pos);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle_ok = 1; hi = 0; n = 0;
        while (counting === 1'b1 && n < 60) begin
            hi++;
            if (grant !== 4'b0 || busy !== 1'b0) idle_ok = 0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!idle_ok || hi == 0) begin
            errors++;
            $display("FAIL rst_wait_idle: idle_ok=%0d busy_cycles=%0d expected 1 and >0", idle_ok, hi);
        end
        exp_q.push_back(4'b1000);
        run_window(0, n);
        req = 4'b0;
    endtask

    task automatic test_err_clear();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", err);
        end
    endtask

`ifdef COUNT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] e;
        int n;
        bit early_err;
        cnt_mode = 2;
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        n = 0;
        while (grant === 4'b0 && n < 60) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        checks++;
        if (grant !== e || start_count !== 1'b1) begin
            errors++;
            $display("FAIL to_grant: grant=%b start=%b expected %b 1", grant, start_count, e);
        end
        n = 0; early_err = 0;
        while (done === 4'b0 && n < 40) begin
            if (err !== 1'b0) early_err = 1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 9 || early_err) begin
            errors++;
            $display("FAIL to_cycles: done after %0d cycles expected 9, early_err=%0d", n, early_err);
        end
        checks++;
        if (done !== 4'b0001 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_done: done=%b err=%b expected 0001 1", done, err);
        end
        req = 4'b0;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
            errors++;
            $display("FAIL to_idle: grant=%b busy=%b done=%b expected 0", grant, busy, done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: err=%b expected 1", err);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_reset: err=%b expected 0", err);
        end
        @(negedge clk);
        resetn = 1'b1;
        cnt_mode = 0;
    endtask
`else
    task automatic test_no_timeout();
        bit waiting_ok;
        cnt_mode = 2;
        req = 4'b0001;
        repeat (4) @(negedge clk);
        waiting_ok = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 4'b0 || err !== 1'b0 || grant !== 4'b0001) waiting_ok = 0;
        end
        checks++;
        if (!waiting_ok) begin
            errors++;
            $display("FAIL no_timeout: busy=%b done=%b err=%b grant=%b expected 1 0000 0 0001",
                     busy, done, err, grant);
        end
        req = 4'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cnt_mode = 0;
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_powerup_busy();
        test_round_robin();
        test_drop_req();
        test_reset_mid_window();
        test_err_clear();
`ifdef COUNT_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_window_arbiter.md
Name: count_window_arbiter

Overview:
- Shares the single 0–15 window counter among N_REQ requesters.
- Round-robin arbitration; winner receives exclusive grant for one full counting window.
- Drives the counter's start_count, monitors its counting flag, pulses done to the winner at window end.
- Sits between requesting control blocks and the counter instance; counter itself unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- IDX_W, 3, width of granted-index output; must satisfy 2^IDX_W >= N_REQ
- TIMEOUT, 8, max cycles waiting for counting to rise after start_count (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level, held until done
- grant  out  N_REQ  one-hot grant, held for whole window
- grant_idx  out  IDX_W  binary index of current grant (0 when none)
- done  out  N_REQ  one-cycle pulse to finishing requester
- busy  out  1  high in any state other than IDLE
- start_count  out  1  to counter; one-cycle pulse
- counting  in  1  from counter
- result  in  4  from counter
- window_pos  out  4  result passed through while RUN, else 0
- err  out  1  sticky timeout flag (optional feature only, else tied 0)

Behaviour:
- Reset (resetn=0, async): state IDLE, grant=0, grant_idx=0, done=0, start_count=0, busy=0, rr pointer=0, err=0.
- States: IDLE, START, WAIT_RISE, RUN, FINISH.
- IDLE: accept only when counting==0 and |req. Winner = first set req scanning from pointer upward, wrapping modulo N_REQ.
  - Next edge: grant/grant_idx registered, state START.
  - Counter busy at power-up (counting==1) blocks arbitration until it falls.
- START: start_count=1 for exactly this cycle; next state WAIT_RISE.
- WAIT_RISE: stay until counting==1, then RUN.
- RUN:
  - window_pos=result.
  - Stay while counting==1; on counting==0 go FINISH.
- FINISH:
  - done[winner]=1 this cycle; grant and grant_idx cleared on the same edge that leaves FINISH.
  - Pointer = (winner+1) mod N_REQ.
  - Next state IDLE.
- Latency: req seen in IDLE at edge k → grant at k+1, start_count high cycle k+1..k+2, done pulse 1 cycle after counting falls.
- Requester dropping req mid-window: no effect; window completes, done still pulses.
- req of the winner still high after done: re-arbitrated normally; other pending requesters win first under round-robin.
- Simultaneous requests: exactly one grant; never two bits set in grant.
- No back-to-back overlap: minimum one IDLE cycle between FINISH and next START.
- Reset mid-window: arbiter returns to IDLE immediately. Counter not reset by this block; next grant waits for counting==0.

Optional Feature:
- Macro: COUNT_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_RISE counts cycles.
  - If counting still 0 after TIMEOUT cycles: set err (sticky until reset), pulse done[winner], clear grant, advance pointer, return to IDLE.
- Undefined:
  - WAIT_RISE waits indefinitely.
  - err tied 0; no timeout counter logic.

Test Plan:
- Power-up with counter counting==1 and req=4'b0001 → no grant until counting falls; then grant=0001 next edge, start_count one-cycle pulse.
- req=4'b0001, counter model runs 16 counting cycles → window_pos walks 0..15, done=0001 for one cycle after counting falls, grant=0 same edge.
- req=4'b1111 held, four windows → grant order 0001,0010,0100,1000, then 0001 again; never two grant bits set.
- Pointer=2 with req=4'b0011 → grant=0001 (wrap); next window with req=4'b0011 → grant=0010.
- resetn pulled low during RUN → grant, busy, done, start_count all 0 asynchronously; after release with counting still 1, no grant until counting==0.
- COUNT_ARB_TIMEOUT_EN defined, TIMEOUT=8, counter held idle → after 8 WAIT_RISE cycles err=1, done pulses, IDLE; err stays 1 until reset.
